// File: rtl/usb_bit_stuffer.sv
// -----------------------------------------------------------------------------
// usb_bit_stuffer
//
// Serial line stage that sits directly after the bitstream encoder. For each
// packet it sends a SYNC pattern, then the encoder's data bits with a 0 stuffed
// in after every STUFF_LEN consecutive 1s, and finally EOP (SE0, SE0, J). All
// line bits are NRZI-encoded onto the dp/dm pair. One clock is one bit time.
//
// Parameters:
//   SYNC_BITS  SYNC length: SYNC_BITS-1 zeros followed by a single 1 (>= 2)
//   STUFF_LEN  run length of transmitted 1s that forces a stuffed 0
//
// Ports:
//   clk        clock, one bit time per cycle
//   rst_L      asynchronous active-low reset; the line goes to J at once
//   in_bit     serial data bit from the encoder
//   in_valid   packet in progress, from the encoder
//   pause      combinational; 1 = encoder holds in_bit and does not shift
//   dp, dm     registered USB line pins (J = 1/0, K = 0/1, SE0 = 0/0)
//   line_busy  registered; high from the first SYNC bit through the EOP J
//   eop_done   registered; one-cycle pulse together with the final EOP J
// -----------------------------------------------------------------------------
module usb_bit_stuffer #(
    parameter int SYNC_BITS = 8,
    parameter int STUFF_LEN = 6
) (
    input  logic clk,
    input  logic rst_L,
    input  logic in_bit,
    input  logic in_valid,
    output logic pause,
    output logic dp,
    output logic dm,
    output logic line_busy,
    output logic eop_done
);

    localparam int SW = $clog2(SYNC_BITS);
    localparam int OW = $clog2(STUFF_LEN + 1);

    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_BITS - 1);
    localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LEN);
    localparam logic [OW-1:0] ONES_ONE  = OW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP
    } state_t;

    state_t          state;
    logic [SW-1:0]   sync_cnt;
    logic [OW-1:0]   ones_cnt;
    logic [1:0]      eop_cnt;

    logic            stuff_due;
    logic            take;

    // A pending stuff bit wins over new data, even after in_valid has dropped.
    assign stuff_due = (state == S_DATA) && (ones_cnt == ONES_MAX);
    assign take      = (state == S_DATA) && !stuff_due && in_valid;
    assign pause     = !take;

    // NOTE: every register, including the line pins, is reset asynchronously so
    // the line shows J the instant rst_L falls, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state     <= S_IDLE;
            dp        <= 1'b1;
            dm        <= 1'b0;
            line_busy <= 1'b0;
            eop_done  <= 1'b0;
            sync_cnt  <= '0;
            ones_cnt  <= '0;
            eop_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; each register takes
            // its new value from the pre-edge values of all the others.
            eop_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    dp        <= 1'b1;
                    dm        <= 1'b0;
                    line_busy <= 1'b0;
                    sync_cnt  <= '0;
                    ones_cnt  <= '0;
                    eop_cnt   <= '0;
                    if (in_valid) begin
                        state <= S_SYNC;
                    end
                end

                S_SYNC: begin
                    line_busy <= 1'b1;
                    if (sync_cnt == SYNC_LAST) begin
                        // Final SYNC bit is a 1: line holds, and it opens the
                        // first run of ones.
                        ones_cnt <= ONES_ONE;
                        state    <= in_valid ? S_DATA : S_EOP;
                    end else begin
                        // A 0 swaps J and K.
                        {dp, dm} <= {dm, dp};
                        sync_cnt <= sync_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    line_busy <= 1'b1;
                    if (stuff_due) begin
                        {dp, dm} <= {dm, dp};
                        ones_cnt <= '0;
                    end else if (in_valid) begin
                        if (in_bit) begin
                            ones_cnt <= ones_cnt + 1'b1;
                        end else begin
                            {dp, dm} <= {dm, dp};
                            ones_cnt <= '0;
                        end
                    end else begin
                        // Nothing to send: line holds one cycle, then EOP.
                        state <= S_EOP;
                    end
                end

                S_EOP: begin
                    line_busy <= 1'b1;
                    if (eop_cnt == 2'd2) begin
                        dp       <= 1'b1;
                        dm       <= 1'b0;
                        eop_done <= 1'b1;
                        eop_cnt  <= '0;
                        state    <= S_IDLE;
                    end else begin
                        dp      <= 1'b0;
                        dm      <= 1'b0;
                        eop_cnt <= eop_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// -----------------------------------------------------------------------------
// tb_usb_bit_stuffer
//
// Directed bench for usb_bit_stuffer with default parameters. It acts as the
// encoder (holds in_bit while pause is high) and compares every line bit of
// each packet, plus line_busy and eop_done, against hand-written sequences.
// Line characters: J, K, 0 (SE0).
// -----------------------------------------------------------------------------
module tb_usb_bit_stuffer;

    logic clk;
    logic rst_L;
    logic in_bit;
    logic in_valid;
    logic pause;
    logic dp;
    logic dm;
    logic line_busy;
    logic eop_done;

    int checks = 0;
    int errors = 0;

    usb_bit_stuffer #(
        .SYNC_BITS(8),
        .STUFF_LEN(6)
    ) dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .pause     (pause),
        .dp        (dp),
        .dm        (dm),
        .line_busy (line_busy),
        .eop_done  (eop_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] line_char(input logic p, input logic m);
        case ({p, m})
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    // Starts a packet from IDLE and acts as the encoder. exp lists the line from
    // the first SYNC bit through the IDLE cycle after EOP.
    task automatic run_packet(input string tag, input logic [15:0] bits, input int nbits,
                              input bit zero_len, input string exp, input int exp_takes);
        int idx   = 0;
        int takes = 0;
        int n     = exp.len();
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                int i = k - 2;
                check($sformatf("%s line[%0d]", tag, i), 32'(line_char(dp, dm)), 32'(exp[i]));
                check($sformatf("%s busy[%0d]", tag, i), 32'(line_busy), 32'(i < n - 1));
                check($sformatf("%s eop[%0d]", tag, i), 32'(eop_done), 32'(i == n - 2));
            end
            if (k == n + 1) break;
            in_valid = zero_len ? (k == 0) : (idx < nbits);
            in_bit   = (idx < nbits) ? bits[idx] : 1'b0;
            #1;
            if (in_valid && !pause) begin
                takes++;
                idx++;
            end
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        check($sformatf("%s accepted bits", tag), 32'(takes), 32'(exp_takes));
    endtask

    initial begin
        rst_L    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;

        // Reset held with random inputs.
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_bit   = 1'($urandom_range(0, 1));
            #1;
            check("reset dp", 32'(dp), 32'd1);
            check("reset dm", 32'(dm), 32'd0);
            check("reset pause", 32'(pause), 32'd1);
            check("reset busy", 32'(line_busy), 32'd0);
            check("reset eop", 32'(eop_done), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        rst_L    = 1'b1;
        @(negedge clk);
        check("idle line", 32'(line_char(dp, dm)), 32'("J"));
        check("idle busy", 32'(line_busy), 32'd0);

        // Data 0,1,0,0,1,0,1,1: SYNC, NRZI data, hold, SE0 SE0 J, idle.
        run_packet("short", 16'h00D2, 8, 1'b0, "KJKJKJKKJJKJJKKKK00JJ", 8);

        // Eight 1s: stuffed 0 after the fifth, 9 data line bits.
        run_packet("stuff", 16'h00FF, 8, 1'b0, "KJKJKJKKKKKKKJJJJJ00JJ", 8);

        // Five 1s then in_valid drops: trailing stuffed 0 before EOP.
        run_packet("trail", 16'h001F, 5, 1'b0, "KJKJKJKKKKKKKJJ00JJ", 5);

        // One-cycle in_valid pulse: SYNC straight into EOP.
        run_packet("zero", 16'h0000, 0, 1'b1, "KJKJKJKK00JJ", 0);

        // Reset during DATA with a stream of zeros (line toggling).
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        repeat (13) @(negedge clk);
        #1;
        check("midrst pre line", 32'(line_char(dp, dm)), 32'("K"));
        check("midrst pre pause", 32'(pause), 32'd0);
        check("midrst pre busy", 32'(line_busy), 32'd1);
        #1;
        rst_L = 1'b0;
        #1;
        check("midrst dp", 32'(dp), 32'd1);
        check("midrst dm", 32'(dm), 32'd0);
        check("midrst busy", 32'(line_busy), 32'd0);
        check("midrst pause", 32'(pause), 32'd1);
        check("midrst eop", 32'(eop_done), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        #1;
        check("post rst line", 32'(line_char(dp, dm)), 32'("J"));
        check("post rst busy", 32'(line_busy), 32'd0);
        check("post rst pause", 32'(pause), 32'd1);

        run_packet("after", 16'h00D2, 8, 1'b0, "KJKJKJKKJJKJJKKKK00JJ", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
